// File: rtl/main_mem_arb_pkg.sv
// Shared defaults and arbiter state encoding for the main-memory arbiter slice.
package main_mem_arb_pkg;

    localparam int ADR_W_DEF = 16;
    localparam int DAT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/main_mem_arb_rd_tag_pipe.sv
// In-flight read tracker: a valid/owner shift register of depth RD_LAT that
// raises the owner's rvalid exactly RD_LAT cycles after a read is issued.
module rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_vld,
    input  logic issue_own,
    output logic rvalid0,
    output logic rvalid1
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] own_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q[0] <= issue_vld;
            own_q[0] <= issue_own;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    assign rvalid0 = vld_q[RD_LAT-1] & ~own_q[RD_LAT-1];
    assign rvalid1 = vld_q[RD_LAT-1] &  own_q[RD_LAT-1];

endmodule

// File: rtl/main_mem_arb.sv
// Two-requester main-memory arbiter: combinational round-robin grant with
// burst lock, pass-through write port and a latency-tracked shared read port.
module main_mem_arb
    import main_mem_arb_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DAT_W  = DAT_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [ADR_W-1:0] adr0,
    input  logic [ADR_W-1:0] adr1,
    input  logic [DAT_W-1:0] wdat0,
    input  logic [DAT_W-1:0] wdat1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [DAT_W-1:0] rdat,
    output logic [ADR_W-1:0] main_mem_read_adr,
    output logic             main_mem_write,
    output logic [ADR_W-1:0] main_mem_write_adr,
    output logic [DAT_W-1:0] main_mem_write_dat,
    input  logic [DAT_W-1:0] main_mem_dat
);

    arb_state_t       state_q, state_d;
    logic             last_q;
    logic             g0, g1, any_gnt, sel_we, rd_issue;
    logic [ADR_W-1:0] sel_adr, rd_adr_q, wr_adr_q;
    logic [DAT_W-1:0] sel_wdat, wr_dat_q;
    logic             pipe_rv0, pipe_rv1;

    // last_q names the previous winner, so the other requester wins a tie in IDLE
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        case (state_q)
            OWN0: begin
                g0 = req0;
                g1 = ~req0 & req1;
            end
            OWN1: begin
                g1 = req1;
                g0 = ~req1 & req0;
            end
            default: begin
                if (req0 && req1) begin
                    g0 = last_q;
                    g1 = ~last_q;
                end else begin
                    g0 = req0;
                    g1 = req1;
                end
            end
        endcase
        if (!rst_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (g0 && lock0) begin
            state_d = OWN0;
        end else if (g1 && lock1) begin
            state_d = OWN1;
        end
    end

    assign any_gnt  = g0 | g1;
    assign sel_we   = g1 ? we1   : we0;
    assign sel_adr  = g1 ? adr1  : adr0;
    assign sel_wdat = g1 ? wdat1 : wdat0;
    assign rd_issue = any_gnt & ~sel_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            rd_adr_q <= '0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
        end else begin
            state_q <= state_d;
            if (any_gnt) begin
                last_q <= g1;
            end
            if (rd_issue) begin
                rd_adr_q <= sel_adr;
            end
            if (any_gnt && sel_we) begin
                wr_adr_q <= sel_adr;
                wr_dat_q <= sel_wdat;
            end
        end
    end

    rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_vld(rd_issue),
        .issue_own(g1),
        .rvalid0  (pipe_rv0),
        .rvalid1  (pipe_rv1)
    );

    assign gnt0               = g0;
    assign gnt1               = g1;
    assign main_mem_write     = any_gnt & sel_we;
    assign main_mem_write_adr = main_mem_write ? sel_adr  : wr_adr_q;
    assign main_mem_write_dat = main_mem_write ? sel_wdat : wr_dat_q;
    assign main_mem_read_adr  = rd_issue ? sel_adr : rd_adr_q;
    // Tags still in flight on the reset cycle itself are masked here
    assign rvalid0            = pipe_rv0 & rst_n;
    assign rvalid1            = pipe_rv1 & rst_n;
    assign rdat               = (rvalid0 | rvalid1) ? main_mem_dat : '0;

endmodule

// File: tb/tb_main_mem_arb.sv
// Self-checking bench for main_mem_arb: RD_LAT=1 and RD_LAT=2 instances share
// stimulus and are checked against a queue-based reference model.
module tb_main_mem_arb;

    typedef struct {
        int          due;
        bit          own;
        logic [15:0] dat;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] adr0, adr1, wdat0, wdat1;

    logic        gnt0_a, gnt1_a, rv0_a, rv1_a, mw_a;
    logic [15:0] rdat_a, ra_a, wa_a, wd_a, pa1;
    logic        gnt0_b, gnt1_b, rv0_b, rv1_b, mw_b;
    logic [15:0] rdat_b, ra_b, wa_b, wd_b, pb1, pb2;

    logic [15:0] mem_a   [0:65535];
    logic [15:0] mem_b   [0:65535];
    logic [15:0] ref_mem [0:65535];

    int  m_own, m_last, cyc;
    bit  lg0, lg1;
    rd_t q1[$];
    rd_t q2[$];
    int  n_pass = 0;
    int  n_chk  = 0;

    always #5 clk = ~clk;

    main_mem_arb #(.ADR_W(16), .DAT_W(16), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .adr0(adr0), .adr1(adr1),
        .wdat0(wdat0), .wdat1(wdat1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rv0_a), .rvalid1(rv1_a),
        .rdat(rdat_a), .main_mem_read_adr(ra_a), .main_mem_write(mw_a),
        .main_mem_write_adr(wa_a), .main_mem_write_dat(wd_a), .main_mem_dat(pa1)
    );

    main_mem_arb #(.ADR_W(16), .DAT_W(16), .RD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .adr0(adr0), .adr1(adr1),
        .wdat0(wdat0), .wdat1(wdat1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rv0_b), .rvalid1(rv1_b),
        .rdat(rdat_b), .main_mem_read_adr(ra_b), .main_mem_write(mw_b),
        .main_mem_write_adr(wa_b), .main_mem_write_dat(wd_b), .main_mem_dat(pb2)
    );

    // Synchronous memories with one and two cycles of read latency
    always @(posedge clk) begin
        if (mw_a) mem_a[wa_a] <= wd_a;
        pa1 <= mem_a[ra_a];
    end

    always @(posedge clk) begin
        if (mw_b) mem_b[wa_b] <= wd_b;
        pb1 <= mem_b[ra_b];
        pb2 <= pb1;
    end

    function automatic logic [15:0] init_val(int i);
        return 16'(i * 257) ^ 16'h5A3C;
    endfunction

    // Grant rules: owner keeps priority while requesting, ties in IDLE alternate
    function automatic void exp_gnt(output bit e0, output bit e1);
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst_n !== 1'b1) return;
        if (m_own == 0) begin
            e0 = req0;
            e1 = !req0 && req1;
        end else if (m_own == 1) begin
            e1 = req1;
            e0 = !req1 && req0;
        end else if (req0 && req1) begin
            e0 = (m_last == 1);
            e1 = (m_last == 0);
        end else begin
            e0 = req0;
            e1 = req1;
        end
    endfunction

    function automatic logic [41:0] exp_vec();
        bit          e0, e1, ew;
        logic        v0a, v1a, v0b, v1b;
        logic [15:0] da, db;
        exp_gnt(e0, e1);
        ew  = (e0 && we0) || (e1 && we1);
        v0a = 1'b0; v1a = 1'b0; da = 16'h0;
        v0b = 1'b0; v1b = 1'b0; db = 16'h0;
        if (rst_n === 1'b1 && q1.size() > 0 && q1[0].due == cyc) begin
            v0a = !q1[0].own; v1a = q1[0].own; da = q1[0].dat;
        end
        if (rst_n === 1'b1 && q2.size() > 0 && q2[0].due == cyc) begin
            v0b = !q2[0].own; v1b = q2[0].own; db = q2[0].dat;
        end
        return {e0, e1, e0, e1, ew, ew, v0a, v1a, da, v0b, v1b, db};
    endfunction

    function automatic logic [41:0] obs_vec();
        return {gnt0_a, gnt1_a, gnt0_b, gnt1_b, mw_a, mw_b,
                rv0_a, rv1_a, rdat_a, rv0_b, rv1_b, rdat_b};
    endfunction

    // Advance one clock and apply the same clock edge to the reference model
    task automatic tick();
        bit          e0, e1;
        int          x;
        logic [15:0] a;
        exp_gnt(e0, e1);
        @(posedge clk);
        while (q1.size() > 0 && q1[0].due <= cyc) void'(q1.pop_front());
        while (q2.size() > 0 && q2[0].due <= cyc) void'(q2.pop_front());
        if (rst_n !== 1'b1) begin
            m_own  = -1;
            m_last = 1;
            q1.delete();
            q2.delete();
        end else if (e0 || e1) begin
            x      = e1 ? 1 : 0;
            m_last = x;
            a      = e1 ? adr1 : adr0;
            if (e1 ? we1 : we0) begin
                ref_mem[a] = e1 ? wdat1 : wdat0;
            end else begin
                q1.push_back('{cyc + 1, e1, ref_mem[a]});
                q2.push_back('{cyc + 2, e1, ref_mem[a]});
            end
            m_own = (e1 ? lock1 : lock0) ? x : -1;
        end else begin
            m_own = -1;
        end
        lg0 = e0;
        lg1 = e1;
        cyc++;
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic l,
                        input logic [15:0] a, input logic [15:0] d);
        req0 = r; we0 = w; lock0 = l; adr0 = a; wdat0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l,
                        input logic [15:0] a, input logic [15:0] d);
        req1 = r; we1 = w; lock1 = l; adr1 = a; wdat1 = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [41:0] o, e;
        rst_n = 1'b0;
        set0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        set1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = obs_vec(); e = exp_vec(); n_chk++;
            if (o !== e) $display("FAIL reset_vec cyc=%0d got=%h want=%h", cyc, o, e);
            else n_pass++;
            if (i > 0) begin
                n_chk++;
                if ({ra_a, wa_a, wd_a, ra_b, wa_b, wd_b} !== 96'h0)
                    $display("FAIL reset_adr cyc=%0d got=%h want=0", cyc,
                             {ra_a, wa_a, wd_a, ra_b, wa_b, wd_b});
                else n_pass++;
            end
            tick();
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({gnt0_a, gnt1_a, gnt0_b, gnt1_b} !== 4'b1010)
            $display("FAIL reset_first_gnt got=%b want=1010", {gnt0_a, gnt1_a, gnt0_b, gnt1_b});
        else n_pass++;
        tick();
        set0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = obs_vec(); e = exp_vec(); n_chk++;
            if (o !== e) $display("FAIL reset_drain cyc=%0d got=%h want=%h", cyc, o, e);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_contention();
        logic [41:0] o, e;
        do_reset();
        set0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        set1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(negedge clk);
            o = obs_vec(); e = exp_vec(); n_chk++;
            if (o !== e) $display("FAIL contention_vec cyc=%0d got=%h want=%h", cyc, o, e);
            else n_pass++;
            if (i < 4) begin
                n_chk++;
                if ({gnt0_a, gnt1_a} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                    $display("FAIL contention_gnt i=%0d got=%b want=%b", i, {gnt0_a, gnt1_a},
                             (i % 2 == 0) ? 2'b10 : 2'b01);
                else n_pass++;
            end
            if (i >= 1 && i <= 4) begin
                n_chk++;
                if ({rv0_a, rv1_a, rdat_a} !== ((i % 2 == 1) ? {2'b10, init_val(16'h0010)}
                                                             : {2'b01, init_val(16'h0020)}))
                    $display("FAIL contention_rv i=%0d got=%b/%h", i, {rv0_a, rv1_a}, rdat_a);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_burst();
        logic [41:0] o, e;
        do_reset();
        set1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        for (int i = 0; i < 7; i++) begin
            if (i < 4) set0(1'b1, 1'b0, (i < 2), 16'h0030 + 16'(i), 16'h0);
            else begin
                set0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
                req1 = 1'b0;
            end
            @(negedge clk);
            o = obs_vec(); e = exp_vec(); n_chk++;
            if (o !== e) $display("FAIL burst_vec cyc=%0d got=%h want=%h", cyc, o, e);
            else n_pass++;
            if (i < 4) begin
                n_chk++;
                if ({gnt0_b, gnt1_b} !== ((i < 3) ? 2'b10 : 2'b01))
                    $display("FAIL burst_gnt i=%0d got=%b want=%b", i, {gnt0_b, gnt1_b},
                             (i < 3) ? 2'b10 : 2'b01);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        logic [41:0] o, e;
        do_reset();
        set0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      set1(1'b1, 1'b1, 1'b0, 16'h0100, 16'hBEEF);
            else if (i == 1) set1(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0);
            else             set1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            o = obs_vec(); e = exp_vec(); n_chk++;
            if (o !== e) $display("FAIL wr_rd_vec cyc=%0d got=%h want=%h", cyc, o, e);
            else n_pass++;
            n_chk++;
            case (i)
                0: if ({mw_a, wa_a, wd_a, mw_b, wa_b, wd_b} !== {1'b1, 32'h0100BEEF, 1'b1, 32'h0100BEEF})
                       $display("FAIL wr_port got=%b %h %h want=1 0100 beef", mw_a, wa_a, wd_a);
                   else n_pass++;
                1: if ({ra_a, ra_b, rv0_a, rv1_a, rv0_b, rv1_b} !== {32'h01000100, 4'b0000})
                       $display("FAIL rd_port got=%h rv=%b want=0100 rv=0000", ra_a,
                                {rv0_a, rv1_a, rv0_b, rv1_b});
                   else n_pass++;
                2: if ({rv1_a, rdat_a, rv1_b} !== {1'b1, 16'hBEEF, 1'b0})
                       $display("FAIL raw_lat1 got=%b %h want=1 beef", rv1_a, rdat_a);
                   else n_pass++;
                3: if ({rv1_b, rdat_b, rv1_a} !== {1'b1, 16'hBEEF, 1'b0})
                       $display("FAIL raw_lat2 got=%b %h want=1 beef", rv1_b, rdat_b);
                   else n_pass++;
                default: if ({rv0_a, rv1_a, rv0_b, rv1_b, rdat_a, rdat_b} !== 36'h0)
                       $display("FAIL raw_idle got=%b want=0", {rv0_a, rv1_a, rv0_b, rv1_b});
                   else n_pass++;
            endcase
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        logic [41:0] o, e;
        do_reset();
        set1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 7; i++) begin
            if (i == 0) set0(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
            else        set0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            rst_n = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            o = obs_vec(); e = exp_vec(); n_chk++;
            if (o !== e) $display("FAIL rst_mid_vec cyc=%0d got=%h want=%h", cyc, o, e);
            else n_pass++;
            if (i > 0) begin
                n_chk++;
                if ({rv0_a, rv1_a, rv0_b, rv1_b} !== 4'b0000)
                    $display("FAIL rst_mid_rv i=%0d got=%b want=0000", i, {rv0_a, rv1_a, rv0_b, rv1_b});
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [41:0] o, e;
        do_reset();
        set1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (i < 3) set0(1'b1, 1'b0, 1'b0, 16'h0050 + 16'(i), 16'h0);
            else       set0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            o = obs_vec(); e = exp_vec(); n_chk++;
            if (o !== e) $display("FAIL b2b_vec cyc=%0d got=%h want=%h", cyc, o, e);
            else n_pass++;
            if (i >= 2 && i <= 4) begin
                n_chk++;
                if ({rv0_b, rdat_b} !== {1'b1, ref_mem[16'h0050 + 16'(i - 2)]})
                    $display("FAIL b2b_lat2 i=%0d got=%b %h want=1 %h", i, rv0_b, rdat_b,
                             ref_mem[16'h0050 + 16'(i - 2)]);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [41:0] o, e;
        bit          e0, e1, w;
        logic [15:0] a, d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            // A requester keeps its access stable until it has been granted
            if (!req0 || lg0)
                set0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0, 16'($urandom_range(0, 7)), 16'($urandom));
            if (!req1 || lg1)
                set1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0, 16'($urandom_range(0, 7)), 16'($urandom));
            rst_n = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            o = obs_vec(); e = exp_vec(); n_chk++;
            if (o !== e) $display("FAIL rand_vec cyc=%0d got=%h want=%h", cyc, o, e);
            else n_pass++;
            exp_gnt(e0, e1);
            if (e0 || e1) begin
                a = e1 ? adr1 : adr0;
                d = e1 ? wdat1 : wdat0;
                w = e1 ? we1 : we0;
                n_chk++;
                if (w ? ({wa_a, wd_a, wa_b, wd_b} !== {a, d, a, d}) : ({ra_a, ra_b} !== {a, a}))
                    $display("FAIL rand_adr cyc=%0d we=%0b got=%h/%h/%h want=%h/%h",
                             cyc, w, ra_a, wa_a, wd_a, a, d);
                else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        m_own  = -1;
        m_last = 1;
        cyc    = 0;
        lg0    = 1'b0;
        lg1    = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            mem_a[i]   <= init_val(i);
            mem_b[i]   <= init_val(i);
            ref_mem[i]  = init_val(i);
        end
        test_reset();
        test_contention();
        test_burst();
        test_write_read();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
